// File: rtl/mili_seq_detector_if.sv
// Serial-bit and status bundle shared between the pattern detector and whatever steps it.
// Widths track the detector's N and CNT_W so one interface definition serves every size.
interface mili_seq_detector_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             i_en;
    logic             i_a;
    logic             i_overlap;
    logic             i_load;
    logic [N-1:0]     i_pattern;
    logic             i_clr_cnt;
    logic             o_y;
    logic [CNT_W-1:0] o_hit_cnt;
    logic             o_primed;

    modport master (
        output i_en, i_a, i_overlap, i_load, i_pattern, i_clr_cnt,
        input  o_y, o_hit_cnt, o_primed
    );

    modport slave (
        input  i_en, i_a, i_overlap, i_load, i_pattern, i_clr_cnt,
        output o_y, o_hit_cnt, o_primed
    );
endinterface

// File: rtl/mili_seq_detector.sv
// Mealy detector for a loadable N-bit serial pattern, one bit per en strobe.
// Match output is combinational on the last bit; also keeps a saturating hit count.
module mili_seq_detector #(
    parameter int           N       = 4,
    parameter int           CNT_W   = 8,
    parameter logic [N-1:0] PAT_RST = 4'b1001
) (
    input logic                clk,
    input logic                rst,
    mili_seq_detector_if.slave bus
);
    localparam int FILL_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N - 1);

    logic [N-1:0]      r_pat;
    logic [N-2:0]      r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [CNT_W-1:0]  r_cnt;

    logic [N-1:0]      w_patNext;
    logic [N-2:0]      w_histNext;
    logic [FILL_W-1:0] w_fillNext;
    logic [CNT_W-1:0]  w_cntNext;
    logic [N-1:0]      w_window;
    logic              w_primed;
    logic              w_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat  <= PAT_RST;
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
        end else begin
            r_pat  <= w_patNext;
            r_hist <= w_histNext;
            r_fill <= w_fillNext;
            r_cnt  <= w_cntNext;
        end
    end

    // The window is the stored history with the live bit appended as the newest.
    always_comb begin
        w_window   = {r_hist, bus.i_a};
        w_primed   = (r_fill == FILL_MAX);
        w_y        = bus.i_en & ~bus.i_load & w_primed & (w_window == r_pat);

        w_patNext  = r_pat;
        w_histNext = r_hist;
        w_fillNext = r_fill;
        w_cntNext  = r_cnt;

        if (bus.i_load) begin
            w_patNext  = bus.i_pattern;
            w_histNext = '0;
            w_fillNext = '0;
        end else if (bus.i_en) begin
            w_histNext = w_window[N-2:0];
            // Non-overlap mode throws away history so the next hit needs N fresh bits.
            if (w_y && !bus.i_overlap) begin
                w_fillNext = '0;
            end else if (!w_primed) begin
                w_fillNext = r_fill + FILL_W'(1);
            end
        end

        if (bus.i_clr_cnt) begin
            w_cntNext = '0;
        end else if (w_y && (r_cnt != '1)) begin
            w_cntNext = r_cnt + CNT_W'(1);
        end
    end

    assign bus.o_y       = w_y;
    assign bus.o_primed  = w_primed;
    assign bus.o_hit_cnt = r_cnt;
endmodule

// File: tb/tb_mili_seq_detector.sv
// Directed bench for mili_seq_detector: default 8-bit counter instance plus a
// 2-bit counter instance reset to pattern 1111 for saturation and clear.
module tb_mili_seq_detector;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mili_seq_detector_if #(.N(4), .CNT_W(8)) busA ();
    mili_seq_detector_if #(.N(4), .CNT_W(2)) busB ();

    mili_seq_detector #(.N(4), .CNT_W(8), .PAT_RST(4'b1001)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    mili_seq_detector #(.N(4), .CNT_W(2), .PAT_RST(4'b1111)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 time unit after the edge; outputs are read 1 unit later.
    task automatic applyStimulus(input logic en, input logic a, input logic load, input logic clr);
        busA.i_en      = en;
        busA.i_a       = a;
        busA.i_load    = load;
        busA.i_clr_cnt = clr;
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        busA.i_en = 1'b0; busA.i_a = 1'b0; busA.i_load = 1'b0; busA.i_clr_cnt = 1'b0;
        busA.i_overlap = 1'b1; busA.i_pattern = 4'b0000;
        busB.i_en = 1'b0; busB.i_a = 1'b0; busB.i_load = 1'b0; busB.i_clr_cnt = 1'b0;
        busB.i_overlap = 1'b1; busB.i_pattern = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (busA.o_y !== 1'b0) begin errors++; $display("[TB] FAIL reset_y got=%b exp=0", busA.o_y); end
        checks++;
        if (busA.o_primed !== 1'b0) begin errors++; $display("[TB] FAIL reset_primed got=%b exp=0", busA.o_primed); end
        checks++;
        if (busA.o_hit_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d exp=0", busA.o_hit_cnt); end
        checks++;
        if (busB.o_hit_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_cntB got=%0d exp=0", busB.o_hit_cnt); end
    endtask

    task automatic runStream(input string name, input logic ovl);
        logic [6:0] bits;
        logic [6:0] expY;
        logic [6:0] expP;
        bits = 7'b1001001;
        if (ovl) begin
            expY = 7'b0001001;
            expP = 7'b0001111;
        end else begin
            expY = 7'b0001000;
            expP = 7'b0001000;
        end
        doReset();
        busA.i_overlap = ovl;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, bits[6-i], 1'b0, 1'b0);
            checks++;
            if (busA.o_y !== expY[6-i]) begin
                errors++; $display("[TB] FAIL %s_y bit%0d got=%b exp=%b", name, i+1, busA.o_y, expY[6-i]);
            end
            checks++;
            if (busA.o_primed !== expP[6-i]) begin
                errors++; $display("[TB] FAIL %s_primed bit%0d got=%b exp=%b", name, i+1, busA.o_primed, expP[6-i]);
            end
            tick();
        end
    endtask

    task automatic test_overlap();
        runStream("ovl", 1'b1);
        checks++;
        if (busA.o_hit_cnt !== 8'd2) begin errors++; $display("[TB] FAIL ovl_cnt got=%0d exp=2", busA.o_hit_cnt); end
    endtask

    task automatic test_non_overlap();
        runStream("novl", 1'b0);
        checks++;
        if (busA.o_hit_cnt !== 8'd1) begin errors++; $display("[TB] FAIL novl_cnt got=%0d exp=1", busA.o_hit_cnt); end
    endtask

    task automatic test_en_gating();
        logic [2:0] pre;
        pre = 3'b100;
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, pre[2-i], 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (busA.o_y !== 1'b0) begin errors++; $display("[TB] FAIL gate_idle_y cyc%0d got=%b exp=0", i, busA.o_y); end
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (busA.o_y !== 1'b1) begin errors++; $display("[TB] FAIL gate_hit_y got=%b exp=1", busA.o_y); end
        tick();
        checks++;
        if (busA.o_hit_cnt !== 8'd1) begin errors++; $display("[TB] FAIL gate_cnt got=%0d exp=1", busA.o_hit_cnt); end
    endtask

    task automatic test_load();
        logic [2:0] pre;
        logic [7:0] bits;
        logic [7:0] expY;
        pre  = 3'b100;
        bits = 8'b0110_1001;
        expY = 8'b0001_0000;
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, pre[2-i], 1'b0, 1'b0);
            tick();
        end
        busA.i_pattern = 4'b0110;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (busA.o_y !== 1'b0) begin errors++; $display("[TB] FAIL load_y got=%b exp=0", busA.o_y); end
        tick();
        checks++;
        if (busA.o_primed !== 1'b0) begin errors++; $display("[TB] FAIL load_primed got=%b exp=0", busA.o_primed); end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, bits[7-i], 1'b0, 1'b0);
            checks++;
            if (busA.o_y !== expY[7-i]) begin
                errors++; $display("[TB] FAIL load_stream_y bit%0d got=%b exp=%b", i+1, busA.o_y, expY[7-i]);
            end
            tick();
        end
        checks++;
        if (busA.o_hit_cnt !== 8'd1) begin errors++; $display("[TB] FAIL load_cnt got=%0d exp=1", busA.o_hit_cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] expCnt [7];
        logic [6:0] expY;
        expCnt = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        expY   = 7'b0001111;
        doReset();
        busB.i_overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            busB.i_en = 1'b1; busB.i_a = 1'b1; busB.i_clr_cnt = 1'b0;
            #1;
            checks++;
            if (busB.o_y !== expY[6-i]) begin
                errors++; $display("[TB] FAIL sat_y bit%0d got=%b exp=%b", i+1, busB.o_y, expY[6-i]);
            end
            tick();
            checks++;
            if (busB.o_hit_cnt !== expCnt[i]) begin
                errors++; $display("[TB] FAIL sat_cnt bit%0d got=%0d exp=%0d", i+1, busB.o_hit_cnt, expCnt[i]);
            end
        end
        busB.i_clr_cnt = 1'b1;
        #1;
        checks++;
        if (busB.o_y !== 1'b1) begin errors++; $display("[TB] FAIL clr_hit_y got=%b exp=1", busB.o_y); end
        tick();
        checks++;
        if (busB.o_hit_cnt !== 2'd0) begin errors++; $display("[TB] FAIL clr_cnt got=%0d exp=0", busB.o_hit_cnt); end
        busB.i_clr_cnt = 1'b0;
        tick();
        checks++;
        if (busB.o_hit_cnt !== 2'd1) begin errors++; $display("[TB] FAIL post_clr_cnt got=%0d exp=1", busB.o_hit_cnt); end
        busB.i_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [2:0] pre;
        logic [3:0] bits;
        logic [3:0] expY;
        pre  = 3'b100;
        bits = 4'b1001;
        expY = 4'b0001;
        doReset();
        busA.i_pattern = 4'b0110;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, pre[2-i], 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (busA.o_y !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_y got=%b exp=0", busA.o_y); end
        checks++;
        if (busA.o_primed !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_primed got=%b exp=0", busA.o_primed); end
        tick();
        checks++;
        if (busA.o_hit_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_cnt got=%0d exp=0", busA.o_hit_cnt); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, bits[3-i], 1'b0, 1'b0);
            checks++;
            if (busA.o_y !== expY[3-i]) begin
                errors++; $display("[TB] FAIL rstmid_stream_y bit%0d got=%b exp=%b", i+1, busA.o_y, expY[3-i]);
            end
            tick();
        end
        checks++;
        if (busA.o_hit_cnt !== 8'd1) begin errors++; $display("[TB] FAIL rstmid_final_cnt got=%0d exp=1", busA.o_hit_cnt); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_en_gating();
        test_load();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
